// File: rtl/fetch_ctrl_pkg.sv
// Shared core definitions for the instruction fetch controller:
// FSM state encoding, the NOP word and the default boot vector.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding imem request at a time, a held
// instruction for decode, and redirect handling that drops in-flight responses.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic        i_stall_ID,
    input  logic        i_pc_src_EX,
    input  logic [31:0] i_pc_target_EX,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr_IF,
    output logic [31:0] o_pc_IF,
    output logic [31:0] o_pcplus4_IF,
    output logic        o_valid_IF
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  instr_q;
    logic [31:0]  pendTarget_q;
    logic         dropPending_q;
    logic         imemReq_q;
    logic         valid_q;

    logic [31:0]  redirTarget;

    assign redirTarget = alignWord(i_pc_target_EX);

    // The request address is pc_q itself, so it cannot move while a request
    // waits for grant; redirects seen before the response only park a target.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= BOOT_ADDR;
            instr_q       <= NOP_INSTR;
            pendTarget_q  <= 32'h0000_0000;
            dropPending_q <= 1'b0;
            imemReq_q     <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q   <= ST_REQ;
                    imemReq_q <= 1'b1;
                end
                ST_REQ: begin
                    if (i_pc_src_EX) begin
                        pendTarget_q  <= redirTarget;
                        dropPending_q <= 1'b1;
                    end
                    if (i_imem_gnt) begin
                        state_q   <= ST_WAIT;
                        imemReq_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (i_pc_src_EX || dropPending_q) begin
                            pc_q          <= i_pc_src_EX ? redirTarget : pendTarget_q;
                            dropPending_q <= 1'b0;
                            state_q       <= ST_REQ;
                            imemReq_q     <= 1'b1;
                        end else begin
                            instr_q <= i_imem_rdata;
                            valid_q <= 1'b1;
                            state_q <= ST_HOLD;
                        end
                    end else if (i_pc_src_EX) begin
                        pendTarget_q  <= redirTarget;
                        dropPending_q <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (i_pc_src_EX) begin
                        pc_q      <= redirTarget;
                        valid_q   <= 1'b0;
                        state_q   <= ST_REQ;
                        imemReq_q <= 1'b1;
                    end else if (!i_stall_ID) begin
                        pc_q      <= pc_q + 32'd4;
                        valid_q   <= 1'b0;
                        state_q   <= ST_REQ;
                        imemReq_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_BOOT;
                    imemReq_q <= 1'b0;
                    valid_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req   = imemReq_q;
    assign o_imem_addr  = pc_q;
    assign o_instr_IF   = instr_q;
    assign o_pc_IF      = pc_q;
    assign o_pcplus4_IF = pc_q + 32'd4;
    assign o_valid_IF   = valid_q;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_stall_ID  input  1  decode cannot accept the held instruction this cycle.
REQ-005 i_pc_src_EX  input  1  redirect request from EX (taken branch/jump).
REQ-006 i_pc_target_EX  input  32  redirect target, sampled when i_pc_src_EX=1.
REQ-007 o_imem_req  output  1  instruction memory request valid.
REQ-008 o_imem_addr  output  32  request address, bits[1:0] always 2'b00.
REQ-009 i_imem_gnt  input  1  memory accepts request when o_imem_req=1.
REQ-010 i_imem_rvalid  input  1  read data valid; exactly one per granted request, at least 1 cycle after gnt.
REQ-011 i_imem_rdata  input  32  instruction word, valid with i_imem_rvalid.
REQ-012 o_instr_IF  output  32  held instruction.
REQ-013 o_pc_IF  output  32  address of the held or currently requested instruction.
REQ-014 o_pcplus4_IF  output  32  o_pc_IF + 4, modulo 2^32.
REQ-015 o_valid_IF  output  1  o_instr_IF is valid for decode.

Function
REQ-016 FSM states are BOOT, REQ, WAIT and HOLD; BOOT lasts exactly one cycle after reset release, then moves to REQ.
REQ-017 REQ: o_imem_req=1 with o_imem_addr=pc; on i_imem_gnt, move to WAIT.
REQ-018 While o_imem_req=1 and gnt=0, o_imem_addr SHALL stay stable; redirects are not applied to the address.
REQ-019 WAIT: o_imem_req=0; on i_imem_rvalid with no drop pending, capture i_imem_rdata into o_instr_IF and move to HOLD.
REQ-020 HOLD: o_valid_IF=1 (registered, equal to state==HOLD).
REQ-021 In HOLD with i_stall_ID=0 and no redirect, the instruction is consumed, pc advances to pc+4, and the FSM moves to REQ.
REQ-022 In HOLD with i_stall_ID=1, all outputs SHALL stay unchanged.
REQ-023 Redirect in HOLD: pc<=i_pc_target_EX with [1:0] cleared, and the FSM moves to REQ; the redirect wins over stall and over sequential advance.
REQ-024 Redirect in REQ or WAIT: latch the target into a pending register and set the drop flag; a later redirect overwrites the pending target.
REQ-025 A response arriving while the drop flag is set SHALL be discarded: o_valid_IF stays 0, pc is loaded from the pending target, flags clear, and the FSM moves to REQ.
REQ-026 A redirect in the same cycle as rvalid in WAIT SHALL discard that response and use the new target.
REQ-027 A redirect in the same cycle as gnt in REQ SHALL move to WAIT with the drop flag set.
REQ-028 Minimum cycles per instruction is 3 (REQ, WAIT, HOLD) with 1-cycle memory latency; no second outstanding request is allowed.
REQ-029 pc+4 wraps at 2^32 without error indication.

Reset
REQ-030 While i_rst_n=0: state=BOOT, pc=BOOT_ADDR, o_imem_req=0, o_valid_IF=0, o_instr_IF=32'h0000_0013 (NOP), drop flag=0, pending target=0.
REQ-031 Reset asserted mid-request SHALL abandon the transaction immediately; a late rvalid arriving in BOOT SHALL be ignored.

Structure
REQ-032 The state enum, NOP encoding and default BOOT_ADDR SHALL live in the shared core package.
REQ-033 The FSM, pc register and redirect/drop logic SHALL be a single module with no sub-modules; the pc+4 adder is inline.

Verification
REQ-034 Reset release, BOOT_ADDR=0, gnt and rvalid 1 cycle later, no stall -> requests to 0x0, 0x4, 0x8 every 3 cycles; o_valid_IF pulses with the matching o_pc_IF.
REQ-035 gnt withheld 4 cycles -> o_imem_req=1 and o_imem_addr=0x4 held constant throughout; redirect to 0x100 during the hold -> next request address is 0x100.
REQ-036 Redirect to 0x200 in WAIT, rvalid 2 cycles later -> data discarded, o_valid_IF stays 0, next o_imem_addr=0x200.
REQ-037 HOLD with i_stall_ID=1 for 5 cycles, then redirect to 0x302 -> outputs frozen, then o_imem_addr=0x300 and o_valid_IF=0.
REQ-038 pc=0xFFFF_FFFC consumed -> next request to 0x0000_0000 and o_pcplus4_IF=0x0 for the held word.
REQ-039 i_rst_n pulled low in WAIT, rvalid arrives during reset -> all outputs at reset values; first request after release goes to BOOT_ADDR.
